instr_fetch: RTL and testbench

- Producer end of the instruction interface: generates the PC, fetches 32-bit instruction words from instruction memory, and presents {instruction, PC} to the decode/control stage over a valid/ready handshake.
- Consumes the branch decision (pc_src) and immediate produced downstream, and redirects fetch to branch_pc + imm_op.
- Sits between instruction memory and the control/decode unit.
- A small prefetch FIFO decouples memory latency from decode stalls.

---
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch.sv | 140 ++++++++++++++
 tb/tb_instr_fetch.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Instruction fetch bus: memory request/response, decode handshake and branch redirect.
// The fetch unit is the master; memory plus decode together form the slave side.
interface instr_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_rvalid;
  logic [31:0]           imem_rdata;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [31:0]           instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  pc_src;
  logic [ADDR_WIDTH-1:0] branch_pc;
  logic [ADDR_WIDTH-1:0] imm_op;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rvalid, imem_rdata, instr_ready, pc_src, branch_pc, imm_op
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_rvalid, imem_rdata, instr_ready, pc_src, branch_pc, imm_op
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC generation, single-outstanding memory fetch, prefetch FIFO toward decode,
// and branch redirect with flush of queued and in-flight instructions.
module instr_fetch #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input logic           clk,
  input logic           rst_n,
  instr_fetch_if.master bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [ADDR_WIDTH-1:0] target_sum, target;
  logic [31:0]           data_mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_q   [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [31:0]           instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  issue, push, pop, flush;

  assign target_sum = bus.branch_pc + bus.imm_op;
  assign target     = target_sum & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  assign flush      = bus.pc_src;
  assign pop        = bus.instr_valid & bus.instr_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a response arriving together with a redirect still retires the request
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (issue) state_d = StWait;
      StWait: begin
        if (bus.imem_rvalid)  state_d = StIdle;
        else if (bus.pc_src)  state_d = StDiscard;
      end
      StDiscard: if (bus.imem_rvalid) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output logic; only IDLE issues, so the in-flight slot is already counted by occupancy
  always_comb begin
    issue         = rst_n && (state_q == StIdle) && (count_q < CntW'(FIFO_DEPTH)) && !bus.pc_src;
    push          = (state_q == StWait) && bus.imem_rvalid && !bus.pc_src;
    bus.imem_req  = issue;
    bus.imem_addr = issue ? fetch_pc_q : '0;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    if (flush) begin
      fetch_pc_d = target;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
      req_addr_d = fetch_pc_q;
    end
  end

  // FIFO bookkeeping; the head is re-registered so it holds its last value when empty
  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
      if (count_d != '0) begin
        if ((count_q - CntW'(pop)) == '0) begin
          instr_d    = bus.imem_rdata;
          instr_pc_d = req_addr_q;
        end else begin
          instr_d    = data_mem_q[rd_ptr_d];
          instr_pc_d = pc_mem_q[rd_ptr_d];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        data_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (push) begin
      data_mem_q[wr_ptr_q] <= bus.imem_rdata;
      pc_mem_q[wr_ptr_q]   <= req_addr_q;
    end
  end

  assign bus.instr_valid = (count_q != '0);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural memory, expected-PC-stream scoreboard and directed
// scenarios followed by randomized ready/latency/redirect traffic.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  instr_fetch_if #(.ADDR_WIDTH(32)) bus ();

  instr_fetch #(
    .ADDR_WIDTH(32),
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: one response per request, data = address >> 2, after lat cycles
  int          lat = 1;
  bit          pend_v = 0;
  logic [31:0] pend_addr;
  int          pend_due;

  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pend_v && cyc == pend_due) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = pend_addr >> 2;
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.imem_rvalid) pend_v = 0;
    if (bus.imem_req) begin
      check("single_outstanding", 64'(pend_v), 64'd0);
      pend_v    = 1;
      pend_addr = bus.imem_addr;
      pend_due  = cyc + lat;
    end
  end

  // Scoreboard: expected delivered PCs restart at RESET_PC or the redirect target
  logic [31:0] exp_q[$];
  logic [31:0] exp_tail;
  logic [31:0] req_addr_log[$];
  int          req_cyc_log[$];
  int          pop_cyc_log[$];
  int          first_valid = -1;
  bit          prev_hold = 0, prev_pc_src = 0;
  logic [31:0] prev_instr, prev_pc;

  task automatic sb_restart(input logic [31:0] start);
    exp_q.delete();
    exp_tail = start;
    exp_q.push_back(start);
  endtask

  task automatic sb_refill();
    while (exp_q.size() < 8) begin
      exp_tail = exp_tail + 32'd4;
      exp_q.push_back(exp_tail);
    end
  endtask

  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (!rst_n) begin
      sb_restart(RESET_PC);
      sb_refill();
      req_addr_log.delete();
      req_cyc_log.delete();
      pop_cyc_log.delete();
      first_valid = -1;
      prev_hold   = 0;
      prev_pc_src = 0;
    end else begin
      if (bus.imem_req) begin
        check("addr_aligned", 64'(bus.imem_addr[1:0]), 64'd0);
        check("no_req_on_redirect", 64'(bus.pc_src), 64'd0);
        req_addr_log.push_back(bus.imem_addr);
        req_cyc_log.push_back(cyc);
      end
      if (prev_pc_src) check("valid_after_flush", 64'(bus.instr_valid), 64'd0);
      if (prev_hold) begin
        check("hold_valid", 64'(bus.instr_valid), 64'd1);
        check("hold_instr", 64'(bus.instr), 64'(prev_instr));
        check("hold_pc", 64'(bus.instr_pc), 64'(prev_pc));
      end
      if (bus.instr_valid && first_valid < 0) first_valid = cyc;
      if (bus.instr_valid && bus.instr_ready) begin
        e = exp_q.pop_front();
        sb_refill();
        check("pop_pc", 64'(bus.instr_pc), 64'(e));
        check("pop_instr", 64'(bus.instr), 64'(e >> 2));
        pop_cyc_log.push_back(cyc);
      end
      if (bus.pc_src) begin
        sb_restart((bus.branch_pc + bus.imm_op) & 32'hFFFF_FFFC);
        sb_refill();
      end
      prev_pc_src = bus.pc_src;
      prev_hold   = bus.instr_valid && !bus.instr_ready && !bus.pc_src;
      prev_instr  = bus.instr;
      prev_pc     = bus.instr_pc;
    end
  end

  task automatic do_reset(input bit rdy);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.instr_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.instr_ready = rdy;
  endtask

  task automatic redirect(input logic [31:0] bp, input logic [31:0] im);
    @(posedge clk);
    #1;
    bus.pc_src    = 1'b1;
    bus.branch_pc = bp;
    bus.imm_op    = im;
    @(posedge clk);
    #1;
    bus.pc_src = 1'b0;
  endtask

  task automatic wait_req(output logic [31:0] a);
    int n = 0;
    @(negedge clk);
    while (!bus.imem_req && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.imem_req) check("req_timeout", 64'd0, 64'd1);
    a = bus.imem_addr;
  endtask

  task automatic wait_counts(input int reqs, input int pops, input string name);
    int n = 0;
    while ((req_addr_log.size() < reqs || pop_cyc_log.size() < pops) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(req_addr_log.size() >= reqs && pop_cyc_log.size() >= pops), 64'd1);
  endtask

  initial begin
    logic [31:0] a;
    rst_n           = 1'b0;
    bus.instr_ready = 1'b0;
    bus.pc_src      = 1'b0;
    bus.branch_pc   = '0;
    bus.imm_op      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", 64'(bus.imem_req), 64'd0);
    check("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
    check("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_instr", 64'(bus.instr), 64'd0);
    check("rst_instr_pc", 64'(bus.instr_pc), 64'd0);

    // Streaming with 1-cycle memory
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    wait_counts(4, 3, "t1_progress");
    if (req_addr_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("t1_req_addr", 64'(req_addr_log[i]), 64'(4 * i));
      check("t1_req_spacing", 64'(req_cyc_log[1] - req_cyc_log[0]), 64'd2);
      check("t1_first_valid_latency", 64'(first_valid - req_cyc_log[0]), 64'd2);
    end

    // Decode stall fills the FIFO, then drains back-to-back
    do_reset(1'b0);
    repeat (10) @(negedge clk);
    check("t2_req_count", 64'(req_addr_log.size()), 64'd2);
    check("t2_head_valid", 64'(bus.instr_valid), 64'd1);
    check("t2_head_pc", 64'(bus.instr_pc), 64'd0);
    @(posedge clk);
    #1;
    bus.instr_ready = 1'b1;
    wait_counts(3, 2, "t2_progress");
    if (pop_cyc_log.size() >= 2 && req_addr_log.size() >= 3) begin
      check("t2_pop_consecutive", 64'(pop_cyc_log[1] - pop_cyc_log[0]), 64'd1);
      check("t2_resume_addr", 64'(req_addr_log[2]), 64'd8);
    end

    // Redirect while a 3-cycle response is in flight
    lat = 3;
    wait_req(a);
    @(posedge clk);
    #1;
    bus.pc_src    = 1'b1;
    bus.branch_pc = 32'h8;
    bus.imm_op    = 32'hFFFF_FFF8;
    @(posedge clk);
    #1;
    bus.pc_src = 1'b0;
    @(negedge clk);
    check("t3_flush_valid", 64'(bus.instr_valid), 64'd0);
    wait_req(a);
    check("t3_target_addr", 64'(a), 64'h0);

    // Redirect coincident with the response
    lat = 2;
    wait_req(a);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.pc_src    = 1'b1;
    bus.branch_pc = 32'h10;
    bus.imm_op    = 32'h20;
    @(posedge clk);
    #1;
    bus.pc_src = 1'b0;
    @(negedge clk);
    check("t4_req", 64'(bus.imem_req), 64'd1);
    check("t4_addr", 64'(bus.imem_addr), 64'h30);
    check("t4_no_push", 64'(bus.instr_valid), 64'd0);

    // Misaligned target and address wrap
    lat = 1;
    redirect(32'h4, 32'h3);
    wait_req(a);
    check("t5_misaligned", 64'(a), 64'h4);
    redirect(32'hFFFF_FFFC, 32'h8);
    wait_req(a);
    check("t5_wrap", 64'(a), 64'h4);

    // Reset during WAIT; the stale response lands in the first post-reset IDLE cycle
    lat = 3;
    wait_req(a);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_req", 64'(bus.imem_req), 64'd1);
    check("t6_addr", 64'(bus.imem_addr), 64'(RESET_PC));
    check("t6_valid0", 64'(bus.instr_valid), 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("t6_no_spurious_valid", 64'(bus.instr_valid), 64'd0);
    end
    wait_counts(1, 1, "t6_progress");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 15) == 0) begin
        bus.pc_src    = 1'b1;
        bus.branch_pc = $urandom;
        bus.imm_op    = $urandom;
      end else begin
        bus.pc_src = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    bus.pc_src      = 1'b0;
    bus.instr_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
